// File: rtl/mips_multicycle_ctrl_if.sv
// Memory-port handshake between the multicycle control FSM and memory.
interface mips_multicycle_ctrl_if;
  logic mem_req_o;
  logic memWrite_o;
  logic iorD_o;
  logic mem_ready_i;

  modport master (
    output mem_req_o,
    output memWrite_o,
    output iorD_o,
    input  mem_ready_i
  );

  modport slave (
    input  mem_req_o,
    input  memWrite_o,
    input  iorD_o,
    output mem_ready_i
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS core, with memory
// ready/timeout handling and a retired-instruction counter.
module mips_multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  mips_multicycle_ctrl_if.master mem,
  input  logic [5:0]             opcode_i,
  input  logic                   zero_i,
  output logic                   irWrite_o,
  output logic                   regDst_o,
  output logic                   memToReg_o,
  output logic                   regWrite_o,
  output logic                   aluSrcA_o,
  output logic [1:0]             aluSrcB_o,
  output logic [1:0]             ALUop_o,
  output logic [1:0]             pcSrc_o,
  output logic                   pcEn_o,
  output logic                   trap_o,
  output logic [CNT_W-1:0]       retired_o
);

  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_TIMEOUT - 1);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD,
    S_MEMWB, S_MEMWR, S_EXEC, S_ALUWB,
    S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP,
    S_TRAP
  } state_t;

  state_t        state, state_n;
  logic [WW-1:0] wait_q, wait_n;
  logic          ready, mem_st, retire;
  logic          is_r, is_lw, is_sw, is_beq, is_addi, is_j;

  assign ready   = mem.mem_ready_i;
  assign is_r    = opcode_i == OP_R;
  assign is_lw   = opcode_i == OP_LW;
  assign is_sw   = opcode_i == OP_SW;
  assign is_beq  = opcode_i == OP_BEQ;
  assign is_addi = opcode_i == OP_ADDI;
  assign is_j    = opcode_i == OP_J;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= S_FETCH;
      wait_q    <= '0;
      retired_o <= '0;
    end else begin
      state  <= state_n;
      wait_q <= wait_n;
      if (retire)
        retired_o <= retired_o + CNT_W'(1);
    end
  end

  always_comb begin
    state_n = state;
    mem_st  = 1'b0;
    unique case (state)
      S_FETCH: begin
        mem_st = 1'b1;
        if (ready) state_n = S_DECODE;
      end
      S_DECODE: begin
        unique case (1'b1)
          is_lw, is_sw: state_n = S_MEMADR;
          is_r:         state_n = S_EXEC;
          is_beq:       state_n = S_BRANCH;
          is_addi:      state_n = S_ADDIEX;
          is_j:         state_n = S_JUMP;
          default:      state_n = S_TRAP;
        endcase
      end
      S_MEMADR: state_n = is_lw ? S_MEMRD : S_MEMWR;
      S_MEMRD: begin
        mem_st = 1'b1;
        if (ready) state_n = S_MEMWB;
      end
      S_MEMWR: begin
        mem_st = 1'b1;
        if (ready) state_n = S_FETCH;
      end
      S_EXEC:   state_n = S_ALUWB;
      S_ADDIEX: state_n = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_BRANCH,
      S_ADDIWB, S_JUMP: state_n = S_FETCH;
      S_TRAP:   state_n = S_TRAP;
      default:  state_n = S_TRAP;
    endcase
    // ready on the last allowed wait cycle still completes the access
    if (mem_st && !ready && wait_q == WAIT_LAST)
      state_n = S_TRAP;
  end

  assign wait_n = (mem_st && !ready && state_n == state) ?
                  wait_q + WW'(1) : '0;
  assign retire = state_n == S_FETCH && state != S_FETCH;

  always_comb begin
    mem.mem_req_o  = 1'b0;
    mem.memWrite_o = 1'b0;
    mem.iorD_o     = 1'b0;
    irWrite_o      = 1'b0;
    regDst_o       = 1'b0;
    memToReg_o     = 1'b0;
    regWrite_o     = 1'b0;
    aluSrcA_o      = 1'b0;
    aluSrcB_o      = 2'b00;
    ALUop_o        = 2'b00;
    pcSrc_o        = 2'b00;
    pcEn_o         = 1'b0;
    trap_o         = 1'b0;
    if (!rst_i) begin
      unique case (state)
        S_FETCH: begin
          mem.mem_req_o = 1'b1;
          aluSrcB_o     = 2'b01;
          irWrite_o     = ready;
          pcEn_o        = ready;
        end
        S_DECODE: aluSrcB_o = 2'b11;
        S_MEMADR, S_ADDIEX: begin
          aluSrcA_o = 1'b1;
          aluSrcB_o = 2'b10;
        end
        S_MEMRD: begin
          mem.mem_req_o = 1'b1;
          mem.iorD_o    = 1'b1;
        end
        S_MEMWB: begin
          memToReg_o = 1'b1;
          regWrite_o = 1'b1;
        end
        S_MEMWR: begin
          mem.mem_req_o  = 1'b1;
          mem.iorD_o     = 1'b1;
          mem.memWrite_o = ready;
        end
        S_EXEC: begin
          aluSrcA_o = 1'b1;
          ALUop_o   = 2'b10;
        end
        S_ALUWB: begin
          regDst_o   = 1'b1;
          regWrite_o = 1'b1;
        end
        S_BRANCH: begin
          aluSrcA_o = 1'b1;
          ALUop_o   = 2'b01;
          pcSrc_o   = 2'b01;
          pcEn_o    = zero_i;
        end
        S_ADDIWB: regWrite_o = 1'b1;
        S_JUMP: begin
          pcSrc_o = 2'b10;
          pcEn_o  = 1'b1;
        end
        S_TRAP:  trap_o = 1'b1;
        default: trap_o = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Randomized bench for mips_multicycle_ctrl against an
// instruction-level step-plan model.
`timescale 1ns/1ps
module tb_mips_multicycle_ctrl;

  localparam int TO = 15;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       src_a;
    logic [1:0] src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       pc_en;
    logic       trap;
  } ctl_t;

  typedef enum {
    ST_FETCH, ST_DECODE, ST_MEMADR, ST_MEMRD, ST_MEMWB,
    ST_MEMWR, ST_EXEC, ST_ALUWB, ST_BRANCH, ST_ADDIEX,
    ST_ADDIWB, ST_JUMP, ST_TRAP
  } step_e;

  logic clk_tb = 1'b0;
  logic rst = 1'b0;
  logic [5:0] opcode = '0;
  logic zero = 1'b0;
  logic ready = 1'b0;

  logic ir_write, reg_dst, mem_to_reg, reg_write, src_a;
  logic [1:0] src_b, alu_op, pc_src;
  logic pc_en, trap;
  logic [31:0] retired;
  logic ir_write4, reg_dst4, mem_to_reg4, reg_write4, src_a4;
  logic [1:0] src_b4, alu_op4, pc_src4;
  logic pc_en4, trap4;
  logic [3:0] retired4;
  ctl_t obs, obs4;

  int n_checks = 0;
  int n_fail = 0;
  int unsigned model_cnt = 0;
  step_e plan[$];
  logic [5:0] legal [6] = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};

  mips_multicycle_ctrl_if mif ();
  mips_multicycle_ctrl_if mif4 ();
  assign mif.mem_ready_i  = ready;
  assign mif4.mem_ready_i = ready;

  mips_multicycle_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(32)) dut (
    .clk_i(clk_tb), .rst_i(rst), .mem(mif.master),
    .opcode_i(opcode), .zero_i(zero),
    .irWrite_o(ir_write), .regDst_o(reg_dst),
    .memToReg_o(mem_to_reg), .regWrite_o(reg_write),
    .aluSrcA_o(src_a), .aluSrcB_o(src_b), .ALUop_o(alu_op),
    .pcSrc_o(pc_src), .pcEn_o(pc_en), .trap_o(trap),
    .retired_o(retired)
  );

  mips_multicycle_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(4)) dut4 (
    .clk_i(clk_tb), .rst_i(rst), .mem(mif4.master),
    .opcode_i(opcode), .zero_i(zero),
    .irWrite_o(ir_write4), .regDst_o(reg_dst4),
    .memToReg_o(mem_to_reg4), .regWrite_o(reg_write4),
    .aluSrcA_o(src_a4), .aluSrcB_o(src_b4), .ALUop_o(alu_op4),
    .pcSrc_o(pc_src4), .pcEn_o(pc_en4), .trap_o(trap4),
    .retired_o(retired4)
  );

  assign obs = {mif.mem_req_o, mif.memWrite_o, mif.iorD_o,
                ir_write, reg_dst, mem_to_reg, reg_write, src_a,
                src_b, alu_op, pc_src, pc_en, trap};
  assign obs4 = {mif4.mem_req_o, mif4.memWrite_o, mif4.iorD_o,
                 ir_write4, reg_dst4, mem_to_reg4, reg_write4, src_a4,
                 src_b4, alu_op4, pc_src4, pc_en4, trap4};

  always #5 clk_tb = ~clk_tb;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void build_plan(logic [5:0] op);
    plan.delete();
    plan.push_back(ST_FETCH);
    plan.push_back(ST_DECODE);
    case (op)
      OP_LW: begin
        plan.push_back(ST_MEMADR);
        plan.push_back(ST_MEMRD);
        plan.push_back(ST_MEMWB);
      end
      OP_SW: begin
        plan.push_back(ST_MEMADR);
        plan.push_back(ST_MEMWR);
      end
      OP_R: begin
        plan.push_back(ST_EXEC);
        plan.push_back(ST_ALUWB);
      end
      OP_BEQ: plan.push_back(ST_BRANCH);
      OP_ADDI: begin
        plan.push_back(ST_ADDIEX);
        plan.push_back(ST_ADDIWB);
      end
      OP_J: plan.push_back(ST_JUMP);
      default: plan.push_back(ST_TRAP);
    endcase
  endfunction

  function automatic bit is_mem(step_e st);
    return st == ST_FETCH || st == ST_MEMRD || st == ST_MEMWR;
  endfunction

  function automatic ctl_t exp_of(step_e st, logic r, logic z);
    ctl_t e = '0;
    case (st)
      ST_FETCH: begin
        e.mem_req = 1; e.src_b = 2'b01; e.ir_write = r; e.pc_en = r;
      end
      ST_DECODE: e.src_b = 2'b11;
      ST_MEMADR, ST_ADDIEX: begin e.src_a = 1; e.src_b = 2'b10; end
      ST_MEMRD: begin e.mem_req = 1; e.iord = 1; end
      ST_MEMWB: begin e.mem_to_reg = 1; e.reg_write = 1; end
      ST_MEMWR: begin e.mem_req = 1; e.iord = 1; e.mem_write = r; end
      ST_EXEC: begin e.src_a = 1; e.alu_op = 2'b10; end
      ST_ALUWB: begin e.reg_dst = 1; e.reg_write = 1; end
      ST_BRANCH: begin
        e.src_a = 1; e.alu_op = 2'b01; e.pc_src = 2'b01; e.pc_en = z;
      end
      ST_ADDIWB: e.reg_write = 1;
      ST_JUMP: begin e.pc_src = 2'b10; e.pc_en = 1; end
      ST_TRAP: e.trap = 1;
      default: e = '0;
    endcase
    return e;
  endfunction

  // enables and trap always matter; selects only where stated
  function automatic ctl_t mask_of(step_e st);
    ctl_t m = '0;
    m.mem_req = 1; m.mem_write = 1; m.ir_write = 1;
    m.reg_write = 1; m.pc_en = 1; m.trap = 1;
    case (st)
      ST_FETCH: begin
        m.iord = 1; m.src_a = 1; m.src_b = '1;
        m.alu_op = '1; m.pc_src = '1;
      end
      ST_DECODE, ST_MEMADR, ST_EXEC, ST_ADDIEX: begin
        m.src_a = 1; m.src_b = '1; m.alu_op = '1;
      end
      ST_MEMRD, ST_MEMWR: m.iord = 1;
      ST_MEMWB, ST_ALUWB, ST_ADDIWB: begin
        m.reg_dst = 1; m.mem_to_reg = 1;
      end
      ST_BRANCH: begin
        m.src_a = 1; m.src_b = '1; m.alu_op = '1; m.pc_src = '1;
      end
      ST_JUMP: m.pc_src = '1;
      default: m.trap = 1;
    endcase
    return m;
  endfunction

  task automatic apply_reset(input string tag);
    rst = 1; ready = 1; #1;
    n_checks++;
    if (obs !== '0 || obs4 !== '0) begin
      n_fail++;
      $display("FAIL %s_async: ctl=%h required 0", tag, obs);
    end
    n_checks++;
    if (retired !== '0 || retired4 !== '0) begin
      n_fail++;
      $display("FAIL %s_cnt: retired=%0d/%0d required 0",
               tag, retired, retired4);
    end
    @(posedge clk_tb); #1;
    n_checks++;
    if (obs !== '0) begin
      n_fail++;
      $display("FAIL %s_hold: ctl=%h required 0", tag, obs);
    end
    rst = 0;
    model_cnt = 0;
  endtask

  // fw/mw: wait cycles before ready in FETCH / data access
  task automatic exec_instr(input logic [5:0] op, input logic z,
                            input int fw, input int mw,
                            input string tag);
    step_e st;
    ctl_t e, m;
    logic r;
    int k;
    bit trapped, done;
    build_plan(op);
    trapped = 0;
    for (int i = 0; i < plan.size() && !trapped; i++) begin
      st = plan[i];
      if (st == ST_TRAP) begin
        trapped = 1;
      end else begin
        k = 0;
        done = 0;
        while (!done) begin
          r = is_mem(st) ? (k >= ((st == ST_FETCH) ? fw : mw))
                         : 1'($urandom);
          ready = r;
          zero = z;
          opcode = (st == ST_FETCH) ? 6'($urandom) : op;
          @(negedge clk_tb);
          e = exp_of(st, r, z);
          m = mask_of(st);
          n_checks++;
          if ((obs & m) !== (e & m) || obs4 !== obs) begin
            n_fail++;
            $display("FAIL %s %s w%0d: ctl=%h required %h mask %h",
                     tag, st.name(), k, obs & m, e & m, m);
          end
          @(posedge clk_tb); #1;
          if (!is_mem(st) || r) done = 1;
          else begin
            k++;
            if (k == TO) begin
              trapped = 1;
              done = 1;
            end
          end
        end
        if (!trapped && i == plan.size() - 1) model_cnt++;
        n_checks++;
        if (retired !== model_cnt || retired4 !== 4'(model_cnt)) begin
          n_fail++;
          $display("FAIL %s retired after %s: %0d/%0d required %0d",
                   tag, st.name(), retired, retired4, model_cnt);
        end
      end
    end
    if (trapped) begin
      for (int c = 0; c < 3; c++) begin
        ready = 1'($urandom);
        zero = 1'($urandom);
        opcode = 6'($urandom);
        @(negedge clk_tb);
        n_checks++;
        if (obs !== exp_of(ST_TRAP, 0, 0) || retired !== model_cnt) begin
          n_fail++;
          $display("FAIL %s trap c%0d: ctl=%h cnt=%0d required %h %0d",
                   tag, c, obs, retired, exp_of(ST_TRAP, 0, 0),
                   model_cnt);
        end
        @(posedge clk_tb); #1;
      end
    end
  endtask

  task automatic test_reset();
    apply_reset("reset");
  endtask

  task automatic test_rtype();
    exec_instr(OP_R, 0, 0, 0, "rtype");
    exec_instr(OP_ADDI, 1, 0, 0, "addi");
    exec_instr(OP_SW, 0, 0, 0, "sw");
  endtask

  task automatic test_lw_wait();
    exec_instr(OP_LW, 0, 0, 3, "lw_wait3");
  endtask

  task automatic test_beq();
    exec_instr(OP_BEQ, 1, 0, 0, "beq_taken");
    exec_instr(OP_BEQ, 0, 0, 0, "beq_not");
  endtask

  task automatic test_illegal();
    logic [5:0] op;
    exec_instr(6'b111111, 0, 0, 0, "illegal_3f");
    apply_reset("illegal_rst");
    for (int n = 0; n < 4; n++) begin
      op = 6'($urandom);
      while (op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J})
        op = 6'($urandom);
      exec_instr(OP_J, 0, 0, 0, "pre_illegal");
      exec_instr(op, 0, $urandom_range(2), 0, "illegal_rand");
      apply_reset("illegal_rrst");
    end
  endtask

  task automatic test_timeout();
    exec_instr(OP_J, 0, TO, 0, "fetch_timeout");
    apply_reset("to_rst1");
    exec_instr(OP_J, 0, TO - 1, 0, "fetch_last_wait");
    exec_instr(OP_LW, 0, 0, TO - 1, "memrd_last_wait");
    exec_instr(OP_LW, 0, 0, TO, "memrd_timeout");
    apply_reset("to_rst2");
    exec_instr(OP_SW, 0, 1, TO, "memwr_timeout");
    apply_reset("to_rst3");
  endtask

  task automatic test_reset_mid();
    apply_reset("mid_pre");
    exec_instr(OP_R, 0, 0, 0, "mid_warm");
    opcode = OP_SW;
    ready = 1;
    repeat (3) begin @(posedge clk_tb); #1; end
    ready = 0; #1;
    n_checks++;
    if (mif.memWrite_o !== 1'b0 || mif.mem_req_o !== 1'b1) begin
      n_fail++;
      $display("FAIL memwr_wait: we=%b req=%b required 0 1",
               mif.memWrite_o, mif.mem_req_o);
    end
    ready = 1; #1;
    n_checks++;
    if (mif.memWrite_o !== 1'b1) begin
      n_fail++;
      $display("FAIL memwr_strobe: we=%b required 1", mif.memWrite_o);
    end
    rst = 1; #1;
    n_checks++;
    if (obs !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_async: ctl=%h required 0", obs);
    end
    @(posedge clk_tb); #1;
    rst = 0;
    model_cnt = 0;
    exec_instr(OP_J, 0, 0, 0, "mid_restart");
  endtask

  task automatic test_wrap();
    apply_reset("wrap_rst");
    for (int n = 0; n < 16; n++)
      exec_instr(OP_J, 1'($urandom), $urandom_range(2), 0, "wrap_j");
    n_checks++;
    if (retired4 !== 4'd0 || retired !== 32'd16) begin
      n_fail++;
      $display("FAIL wrap: retired=%0d/%0d required 16/0",
               retired, retired4);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] op;
    int fw, mw;
    for (int n = 0; n < 40; n++) begin
      op = legal[$urandom_range(5)];
      fw = ($urandom_range(7) == 0) ? $urandom_range(TO - 1)
                                    : $urandom_range(2);
      mw = ($urandom_range(7) == 0) ? $urandom_range(TO - 1)
                                    : $urandom_range(3);
      exec_instr(op, 1'($urandom), fw, mw, "b2b");
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_wait();
    test_beq();
    test_illegal();
    test_timeout();
    test_reset_mid();
    test_wrap();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
